nunchuk_poll_ctrl: RTL and testbench
====================================

// Module: nunchuk_poll_ctrl
// PURPOSE
//  Sequencer for the I2C master command interface. After enable, runs the 2-write
//  Nunchuk init handshake, then polls the 6-byte sample every POLL_DIV cycles.
//  Latches results and decodes joystick and buttons for the visualizer control path.
//  Sole owner of the master's command inputs; sits between the I2C master and user logic.
// PARAMETERS
//  DEV_ADDR  7'h52  slave address driven on every command
//  POLL_DIV  20000  idle cycles from end of one read to start of next pointer write (>=1)
//  TIMEOUT   50000  cycles to wait for i2c_done before a command counts as failed (>=2)
//  MAX_RETRY 3      consecutive failures before sticky error (1..7)
// PORTS
//  i2c_clock    in   1   sole clock, rising edge
//  reset        in   1   asynchronous, active-high
//  enable       in   1   level; run sequencer while high
//  i2c_dev_addr out  7   to master deviceAddr
//  i2c_reg_addr out  8   to master addr
//  i2c_num_bytes out 3   bytes in this command (0..6)
//  i2c_data_in  out  48  write payload; [7:0] sent first
//  i2c_write    out  1   0=write, 1=read (master encoding)
//  i2c_start    out  1   1-cycle command strobe
//  i2c_done     in   1   1-cycle completion pulse from master
//  i2c_data_out in   48  read data; [7:0] = first byte received
//  sample       out  48  last good read, same byte order
//  sample_valid out  1   1-cycle pulse when sample updates
//  joy_x, joy_y out  8   sample[7:0], sample[15:8]
//  btn_z, btn_c out  1   ~sample[40], ~sample[41] (buttons active-low on wire)
//  init_done    out  1   high once handshake done, until enable low/error/reset
//  error        out  1   sticky after MAX_RETRY consecutive failures
// BEHAVIOUR
//  Reset (async): all outputs 0 (btn_z/btn_c =1 via decode of sample=0), state IDLE, counters 0.
//  States: IDLE, HS1, W_HS1, HS2, W_HS2, POLL_WAIT, PTR, W_PTR, READ, W_READ, ERR.
//  IDLE: enable=1 -> HS1.
//  HS1: cmd reg F0, 1 byte, data[7:0]=55, write=0; start=1 one cycle -> W_HS1.
//  HS2: cmd reg FB, 1 byte, data[7:0]=00, write=0; start -> W_HS2.
//  PTR: reg 00, 0 bytes, write=0; start -> W_PTR.
//  READ: reg 00, 6 bytes, write=1; start -> W_READ.
//  Done routing: W_HS1 -> HS2; W_HS2 -> POLL_WAIT, init_done<=1; W_PTR -> READ.
//  W_READ done -> sample<=i2c_data_out, sample_valid pulse next cycle -> POLL_WAIT.
//  Command fields registered in the start cycle; held stable until done or timeout.
//  Unused data_in bits are 0.
//  i2c_done sampled only in W_* states; done in any other state (incl. start cycle) ignored.
//  W_* timer: counts cycles from the cycle after start.
//  Timeout: timer==TIMEOUT without done counts a failure -> fail_cnt+1, init_done<=0, go HS1.
//  Retry: if fail_cnt reaches MAX_RETRY -> ERR instead.
//  Any done clears fail_cnt.
//  POLL_WAIT: counter loads 0 on entry; -> PTR when count==POLL_DIV-1 (POLL_DIV idle cycles).
//  ERR: error=1, no starts; exit to IDLE only when enable=0 (clears error, fail_cnt).
//  enable=0 in IDLE/HS*/PTR/READ/POLL_WAIT: -> IDLE next cycle, init_done<=0, no start issued.
//  enable=0 in W_*: wait for done or timeout (bus not aborted), discard data, then -> IDLE.
//   No sample_valid and no fail count in that case.
//  Re-enable always restarts from HS1; sample retains last value until overwritten.
//  Mid-operation reset forces IDLE immediately; the master is reset by the same signal.
// TESTING
//  1 Reset, enable=1, model done 10 cycles after start -> HS1 cmd 52/F0/n=1/data 55/wr0.
//    Then FB/00; init_done=1 one cycle after 2nd done.
//  2 POLL_DIV=20: after init, exactly 20 idle cycles -> PTR (00,n=0,wr0) -> READ (00,n=6,wr1).
//    Model data_out=48'hFD90A0B07A85 -> sample_valid 1 cycle; joy_x=85, joy_y=7A, btn_z=0, btn_c=1.
//  3 TIMEOUT=30, MAX_RETRY=3, model never done -> 3 HS1 starts 31 cycles apart.
//    Then error=1, no further start; enable=0 -> error=0, IDLE.
//  4 enable=0 two cycles after READ start, done 8 cycles later -> no sample_valid, sample unchanged.
//    IDLE, init_done=0; re-enable -> HS1 issued.
//  5 Async reset asserted mid W_READ (between clock edges) -> all outputs 0 immediately.
//    After release with enable=1 -> HS1.
//  6 Fail once then succeed: timeout on PTR -> HS1 restart, fail_cnt cleared by next done.
//    Two more isolated timeouts never set error.

Source files
------------

// File: rtl/nunchuk_poll_ctrl_if.sv
// Command/response bundle between the Nunchuk poll sequencer and the I2C master.
// The "master" modport is the command issuer (sequencer); "slave" is the I2C engine.
interface nunchuk_poll_ctrl_if;
  localparam int unsigned DATA_W = 48;

  logic [6:0]        i2c_dev_addr;
  logic [7:0]        i2c_reg_addr;
  logic [2:0]        i2c_num_bytes;
  logic [DATA_W-1:0] i2c_data_in;
  logic              i2c_write;
  logic              i2c_start;
  logic              i2c_done;
  logic [DATA_W-1:0] i2c_data_out;

  modport master (
    output i2c_dev_addr, i2c_reg_addr, i2c_num_bytes, i2c_data_in, i2c_write, i2c_start,
    input  i2c_done, i2c_data_out
  );

  modport slave (
    input  i2c_dev_addr, i2c_reg_addr, i2c_num_bytes, i2c_data_in, i2c_write, i2c_start,
    output i2c_done, i2c_data_out
  );
endinterface

// File: rtl/nunchuk_poll_ctrl.sv
// Nunchuk sequencer: runs the two-write init handshake, then periodically polls the
// 6-byte sample through the I2C master, with timeout/retry and joystick/button decode.
module nunchuk_poll_ctrl #(
  parameter logic [6:0]  DEV_ADDR  = 7'h52,
  parameter int unsigned POLL_DIV  = 20000,
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                 i2c_clock,
  input  logic                 reset,
  input  logic                 enable_i,
  nunchuk_poll_ctrl_if.master  i2c,
  output logic [47:0]          sample_o,
  output logic                 sample_valid_o,
  output logic [7:0]           joy_x_o,
  output logic [7:0]           joy_y_o,
  output logic                 btn_z_o,
  output logic                 btn_c_o,
  output logic                 init_done_o,
  output logic                 error_o
);

  localparam int unsigned DATA_W = 48;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned POLL_W = $clog2(POLL_DIV + 1);
  localparam int unsigned FAIL_W = 3;

  typedef enum logic [3:0] {
    IDLE, HS1, W_HS1, HS2, W_HS2, POLL_WAIT, PTR, W_PTR, READ, W_READ, ERR
  } state_e;

  state_e              state_q;
  logic [6:0]          dev_q;
  logic [7:0]          reg_q;
  logic [2:0]          num_q;
  logic [DATA_W-1:0]   data_q;
  logic                wr_q;
  logic                start_q;
  logic [TMR_W-1:0]    timer_q;
  logic [POLL_W-1:0]   poll_q;
  logic [FAIL_W-1:0]   fail_q;
  logic                abort_q;
  logic [DATA_W-1:0]   sample_q;
  logic                valid_q;
  logic [7:0]          joy_x_q;
  logic [7:0]          joy_y_q;
  logic                btn_z_q;
  logic                btn_c_q;
  logic                init_q;
  logic                err_q;

  logic                issue_c;
  logic [7:0]          cmd_reg_c;
  logic [2:0]          cmd_num_c;
  logic [DATA_W-1:0]   cmd_data_c;
  logic                cmd_wr_c;
  state_e              cmd_wait_c;
  logic                in_wait_c;
  logic                done_hit_c;
  logic                tmo_hit_c;
  logic                quit_c;

  // Command table for the four issuing states; a start is only issued while enabled.
  always_comb begin
    issue_c    = 1'b0;
    cmd_reg_c  = 8'h00;
    cmd_num_c  = 3'd0;
    cmd_data_c = '0;
    cmd_wr_c   = 1'b0;
    cmd_wait_c = IDLE;
    case (state_q)
      HS1: begin
        issue_c    = enable_i;
        cmd_reg_c  = 8'hF0;
        cmd_num_c  = 3'd1;
        cmd_data_c = DATA_W'(8'h55);
        cmd_wait_c = W_HS1;
      end
      HS2: begin
        issue_c    = enable_i;
        cmd_reg_c  = 8'hFB;
        cmd_num_c  = 3'd1;
        cmd_wait_c = W_HS2;
      end
      PTR: begin
        issue_c    = enable_i;
        cmd_wait_c = W_PTR;
      end
      READ: begin
        issue_c    = enable_i;
        cmd_num_c  = 3'd6;
        cmd_wr_c   = 1'b1;
        cmd_wait_c = W_READ;
      end
      default: ;
    endcase
  end

  // The start cycle itself never accepts done and never times out (TIMEOUT >= 2).
  assign in_wait_c  = (state_q == W_HS1) || (state_q == W_HS2) ||
                      (state_q == W_PTR) || (state_q == W_READ);
  assign done_hit_c = in_wait_c && !start_q && i2c.i2c_done;
  assign tmo_hit_c  = in_wait_c && !done_hit_c && (timer_q == TMR_W'(TIMEOUT - 1));
  assign quit_c     = abort_q || !enable_i;

  always_ff @(posedge i2c_clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dev_q    <= '0;
      reg_q    <= '0;
      num_q    <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      start_q  <= 1'b0;
      timer_q  <= '0;
      poll_q   <= '0;
      fail_q   <= '0;
      abort_q  <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      joy_x_q  <= '0;
      joy_y_q  <= '0;
      btn_z_q  <= 1'b1;
      btn_c_q  <= 1'b1;
      init_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      if (!enable_i) init_q <= 1'b0;

      if (issue_c) begin
        dev_q   <= DEV_ADDR;
        reg_q   <= cmd_reg_c;
        num_q   <= cmd_num_c;
        data_q  <= cmd_data_c;
        wr_q    <= cmd_wr_c;
        start_q <= 1'b1;
        timer_q <= '0;
        abort_q <= 1'b0;
        state_q <= cmd_wait_c;
      end else begin
        case (state_q)
          IDLE: if (enable_i) state_q <= HS1;

          HS1, HS2, PTR, READ: state_q <= IDLE;

          POLL_WAIT: begin
            if (!enable_i)                            state_q <= IDLE;
            else if (poll_q == POLL_W'(POLL_DIV - 1)) state_q <= PTR;
            else                                      poll_q  <= poll_q + POLL_W'(1);
          end

          W_HS1, W_HS2, W_PTR, W_READ: begin
            timer_q <= timer_q + TMR_W'(1);
            if (!enable_i) abort_q <= 1'b1;
            if (done_hit_c) begin
              fail_q <= '0;
              if (quit_c) begin
                state_q <= IDLE;
              end else begin
                case (state_q)
                  W_HS1: state_q <= HS2;
                  W_HS2: begin
                    state_q <= POLL_WAIT;
                    poll_q  <= '0;
                    init_q  <= 1'b1;
                  end
                  W_PTR: state_q <= READ;
                  default: begin
                    sample_q <= i2c.i2c_data_out;
                    valid_q  <= 1'b1;
                    joy_x_q  <= i2c.i2c_data_out[7:0];
                    joy_y_q  <= i2c.i2c_data_out[15:8];
                    btn_z_q  <= ~i2c.i2c_data_out[40];
                    btn_c_q  <= ~i2c.i2c_data_out[41];
                    state_q  <= POLL_WAIT;
                    poll_q   <= '0;
                  end
                endcase
              end
            end else if (tmo_hit_c) begin
              // A timeout abandoned by enable=0 is not counted as a failure.
              init_q <= 1'b0;
              if (quit_c) begin
                state_q <= IDLE;
              end else if (fail_q == FAIL_W'(MAX_RETRY - 1)) begin
                fail_q  <= fail_q + FAIL_W'(1);
                err_q   <= 1'b1;
                state_q <= ERR;
              end else begin
                fail_q  <= fail_q + FAIL_W'(1);
                state_q <= HS1;
              end
            end
          end

          ERR: begin
            if (!enable_i) begin
              err_q   <= 1'b0;
              fail_q  <= '0;
              state_q <= IDLE;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign i2c.i2c_dev_addr  = dev_q;
  assign i2c.i2c_reg_addr  = reg_q;
  assign i2c.i2c_num_bytes = num_q;
  assign i2c.i2c_data_in   = data_q;
  assign i2c.i2c_write     = wr_q;
  assign i2c.i2c_start     = start_q;

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign joy_x_o        = joy_x_q;
  assign joy_y_o        = joy_y_q;
  assign btn_z_o        = btn_z_q;
  assign btn_c_o        = btn_c_q;
  assign init_done_o    = init_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_nunchuk_poll_ctrl.sv
// Directed bench for nunchuk_poll_ctrl: behavioural I2C master model plus scenario tasks
// with hand-computed expectations (POLL_DIV=20, TIMEOUT=30, MAX_RETRY=3).
module tb_nunchuk_poll_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [47:0] sample;
  logic        sample_valid;
  logic [7:0]  joy_x, joy_y;
  logic        btn_z, btn_c, init_done, error;

  nunchuk_poll_ctrl_if bus ();

  nunchuk_poll_ctrl #(
    .DEV_ADDR (7'h52),
    .POLL_DIV (20),
    .TIMEOUT  (30),
    .MAX_RETRY(3)
  ) dut (
    .i2c_clock     (clk),
    .reset         (rst),
    .enable_i      (enable),
    .i2c           (bus),
    .sample_o      (sample),
    .sample_valid_o(sample_valid),
    .joy_x_o       (joy_x),
    .joy_y_o       (joy_y),
    .btn_z_o       (btn_z),
    .btn_c_o       (btn_c),
    .init_done_o   (init_done),
    .error_o       (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          p_cyc;
  int          resp_delay = 10;
  bit          never_done = 1'b0;
  int          drop_req = 0;
  int          drop_used = 0;
  int          done_cyc = 0;
  logic [47:0] model_data = 48'hFD90A0B07A85;
  int          cnt = 0;

  int          st_cyc[$];
  logic [6:0]  st_dev[$];
  logic [7:0]  st_reg[$];
  logic [2:0]  st_num[$];
  logic [47:0] st_dat[$];
  logic        st_wr[$];

  // I2C master model: logs every start, answers with done resp_delay cycles later.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      cnt = 0;
      bus.i2c_done = 1'b0;
      bus.i2c_data_out = '0;
    end else begin
      bus.i2c_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.i2c_done = 1'b1;
          bus.i2c_data_out = model_data;
          done_cyc = cyc;
        end
      end
      if (bus.i2c_start) begin
        st_cyc.push_back(cyc);
        st_dev.push_back(bus.i2c_dev_addr);
        st_reg.push_back(bus.i2c_reg_addr);
        st_num.push_back(bus.i2c_num_bytes);
        st_dat.push_back(bus.i2c_data_in);
        st_wr.push_back(bus.i2c_write);
        if (never_done) cnt = 0;
        else if (bus.i2c_reg_addr == 8'h00 && bus.i2c_num_bytes == 3'd0 && drop_req > drop_used)
          drop_used++;
        else cnt = resp_delay;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (st_cyc.size() >= n);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int k = 0;
    while (!sample_valid && k < budget) begin
      tick();
      k++;
    end
    ok = sample_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({sample, sample_valid, joy_x, joy_y} !== '0) begin n_fail++;
      $display("FAIL reset_data: got %h/%b/%h/%h want 0", sample, sample_valid, joy_x, joy_y); end
    n_cmp++; if ({btn_z, btn_c} !== 2'b11) begin n_fail++;
      $display("FAIL reset_btn: got %b%b want 11", btn_z, btn_c); end
    n_cmp++; if ({init_done, error, bus.i2c_start} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags: got %b%b%b want 000", init_done, error, bus.i2c_start); end
    n_cmp++; if ({bus.i2c_dev_addr, bus.i2c_reg_addr, bus.i2c_num_bytes, bus.i2c_write} !== '0) begin n_fail++;
      $display("FAIL reset_cmd: got %h/%h/%h/%b want 0", bus.i2c_dev_addr, bus.i2c_reg_addr,
               bus.i2c_num_bytes, bus.i2c_write); end
  endtask

  task automatic test_init();
    bit ok;
    int k = 0;
    rst = 1'b0;
    enable = 1'b1;
    wait_starts(1, 20, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL hs1_start: got none want start"); end
    n_cmp++; if ({st_dev[0], st_reg[0], st_num[0], st_dat[0], st_wr[0]} !== {7'h52, 8'hF0, 3'd1, 48'h55, 1'b0}) begin
      n_fail++; $display("FAIL hs1_cmd: got %h/%h/%h/%h/%b want 52/f0/1/55/0",
                         st_dev[0], st_reg[0], st_num[0], st_dat[0], st_wr[0]); end
    wait_starts(2, 30, ok);
    n_cmp++; if ({st_dev[1], st_reg[1], st_num[1], st_dat[1], st_wr[1]} !== {7'h52, 8'hFB, 3'd1, 48'h0, 1'b0}) begin
      n_fail++; $display("FAIL hs2_cmd: got %h/%h/%h/%h/%b want 52/fb/1/0/0",
                         st_dev[1], st_reg[1], st_num[1], st_dat[1], st_wr[1]); end
    n_cmp++; if (st_cyc[1] - st_cyc[0] !== 12) begin n_fail++;
      $display("FAIL hs_spacing: got %0d want 12", st_cyc[1] - st_cyc[0]); end
    while (!init_done && k < 40) begin tick(); k++; end
    p_cyc = cyc;
    n_cmp++; if (!init_done || (cyc - done_cyc) !== 1) begin n_fail++;
      $display("FAIL init_done_lat: got %b after %0d want 1 after 1", init_done, cyc - done_cyc); end
  endtask

  task automatic test_poll();
    bit ok;
    wait_starts(3, 40, ok);
    n_cmp++; if (st_cyc[2] - p_cyc !== 21) begin n_fail++;
      $display("FAIL poll_gap: got %0d want 21", st_cyc[2] - p_cyc); end
    n_cmp++; if ({st_reg[2], st_num[2], st_wr[2]} !== {8'h00, 3'd0, 1'b0}) begin n_fail++;
      $display("FAIL ptr_cmd: got %h/%h/%b want 00/0/0", st_reg[2], st_num[2], st_wr[2]); end
    wait_starts(4, 30, ok);
    n_cmp++; if ({st_dev[3], st_reg[3], st_num[3], st_wr[3], st_cyc[3] - st_cyc[2]} !== {7'h52, 8'h00, 3'd6, 1'b1, 32'd12}) begin
      n_fail++; $display("FAIL read_cmd: got %h/%h/%h/%b gap %0d want 52/00/6/1 gap 12",
                         st_dev[3], st_reg[3], st_num[3], st_wr[3], st_cyc[3] - st_cyc[2]); end
    wait_valid(20, ok);
    n_cmp++; if (!ok || (cyc - done_cyc) !== 1) begin n_fail++;
      $display("FAIL valid_lat: got %b after %0d want 1 after 1", ok, cyc - done_cyc); end
    n_cmp++; if (sample !== 48'hFD90A0B07A85) begin n_fail++;
      $display("FAIL sample: got %h want fd90a0b07a85", sample); end
    n_cmp++; if ({joy_x, joy_y, btn_z, btn_c} !== {8'h85, 8'h7A, 1'b0, 1'b1}) begin n_fail++;
      $display("FAIL decode: got %h/%h/%b/%b want 85/7a/0/1", joy_x, joy_y, btn_z, btn_c); end
    tick();
    n_cmp++; if (sample_valid !== 1'b0) begin n_fail++;
      $display("FAIL valid_pulse: got %b want 0", sample_valid); end
  endtask

  task automatic test_abort_read();
    bit ok;
    bit seen = 1'b0;
    int e;
    model_data = 48'h001122334455;
    wait_starts(6, 80, ok);
    n_cmp++; if (!ok || st_num[5] !== 3'd6) begin n_fail++;
      $display("FAIL abort_read_start: got %b/%h want 1/6", ok, st_num[5]); end
    tick();
    tick();
    enable = 1'b0;
    repeat (15) begin tick(); if (sample_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got 1 want 0"); end
    n_cmp++; if (sample !== 48'hFD90A0B07A85) begin n_fail++;
      $display("FAIL abort_sample: got %h want fd90a0b07a85", sample); end
    n_cmp++; if ({init_done, error} !== 2'b00 || st_cyc.size() !== 6) begin n_fail++;
      $display("FAIL abort_idle: got %b%b starts %0d want 00 starts 6", init_done, error, st_cyc.size()); end
    e = cyc;
    enable = 1'b1;
    wait_starts(7, 10, ok);
    n_cmp++; if (!ok || st_reg[6] !== 8'hF0 || (st_cyc[6] - e) !== 2) begin n_fail++;
      $display("FAIL reenable_hs1: got %h after %0d want f0 after 2", st_reg[6], st_cyc[6] - e); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    model_data = 48'hFD90A0B07A85;
    wait_starts(10, 120, ok);
    n_cmp++; if (!ok || st_num[9] !== 3'd6) begin n_fail++;
      $display("FAIL mid_read_start: got %b/%h want 1/6", ok, st_num[9]); end
    repeat (3) tick();
    #4;
    rst = 1'b1;
    #1;
    n_cmp++; if ({sample, sample_valid, joy_x, joy_y, init_done, error} !== '0 || {btn_z, btn_c} !== 2'b11) begin
      n_fail++; $display("FAIL async_rst_out: got %h/%b/%h/%h/%b/%b/%b%b want 0s and btn 11",
                         sample, sample_valid, joy_x, joy_y, init_done, error, btn_z, btn_c); end
    n_cmp++; if ({bus.i2c_start, bus.i2c_dev_addr, bus.i2c_num_bytes, bus.i2c_write} !== '0) begin n_fail++;
      $display("FAIL async_rst_cmd: got %b/%h/%h/%b want 0", bus.i2c_start, bus.i2c_dev_addr,
               bus.i2c_num_bytes, bus.i2c_write); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_starts(11, 10, ok);
    n_cmp++; if (!ok || st_reg[10] !== 8'hF0) begin n_fail++;
      $display("FAIL post_rst_hs1: got %b/%h want 1/f0", ok, st_reg[10]); end
  endtask

  task automatic test_timeout_error();
    bit ok;
    int b;
    int k = 0;
    enable = 1'b0;
    repeat (40) tick();
    b = st_cyc.size();
    never_done = 1'b1;
    enable = 1'b1;
    wait_starts(b + 3, 120, ok);
    n_cmp++; if (!ok || (st_cyc[b+1] - st_cyc[b]) !== 31 || (st_cyc[b+2] - st_cyc[b+1]) !== 31) begin n_fail++;
      $display("FAIL retry_spacing: got %0d/%0d want 31/31", st_cyc[b+1] - st_cyc[b], st_cyc[b+2] - st_cyc[b+1]); end
    n_cmp++; if ({st_reg[b], st_reg[b+1], st_reg[b+2]} !== {8'hF0, 8'hF0, 8'hF0}) begin n_fail++;
      $display("FAIL retry_reg: got %h/%h/%h want f0/f0/f0", st_reg[b], st_reg[b+1], st_reg[b+2]); end
    while (!error && k < 40) begin tick(); k++; end
    n_cmp++; if (!error || (cyc - st_cyc[b+2]) !== 30) begin n_fail++;
      $display("FAIL err_lat: got %b after %0d want 1 after 30", error, cyc - st_cyc[b+2]); end
    repeat (40) tick();
    n_cmp++; if (st_cyc.size() !== b + 3 || error !== 1'b1 || init_done !== 1'b0) begin n_fail++;
      $display("FAIL err_hold: got starts %0d err %b init %b want %0d 1 0", st_cyc.size(), error, init_done, b + 3); end
    enable = 1'b0;
    tick();
    tick();
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", error); end
    never_done = 1'b0;
  endtask

  task automatic test_fail_once();
    bit ok;
    int b;
    b = st_cyc.size();
    drop_req = drop_req + 1;
    enable = 1'b1;
    wait_starts(b + 4, 200, ok);
    n_cmp++; if (!ok || {st_reg[b+2], st_num[b+2], st_reg[b+3]} !== {8'h00, 3'd0, 8'hF0}) begin n_fail++;
      $display("FAIL ptr_tmo_restart: got %h/%h then %h want 00/0 then f0", st_reg[b+2], st_num[b+2], st_reg[b+3]); end
    n_cmp++; if ((st_cyc[b+3] - st_cyc[b+2]) !== 31 || init_done !== 1'b0) begin n_fail++;
      $display("FAIL ptr_tmo_timing: got %0d init %b want 31 init 0", st_cyc[b+3] - st_cyc[b+2], init_done); end
    wait_valid(200, ok);
    n_cmp++; if (!ok || error !== 1'b0) begin n_fail++;
      $display("FAIL recover_sample: got valid %b err %b want 1 0", ok, error); end
    for (int r = 0; r < 2; r++) begin
      drop_req = drop_req + 1;
      tick();
      wait_valid(300, ok);
      n_cmp++; if (!ok || error !== 1'b0 || drop_used !== drop_req) begin n_fail++;
        $display("FAIL isolated_tmo%0d: got valid %b err %b drops %0d want 1 0 %0d", r, ok, error, drop_used, drop_req); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_poll();
    test_abort_read();
    test_reset_mid();
    test_timeout_error();
    test_fail_once();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want summary before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
